gray_counter_ud: RTL and testbench
==================================

GRAY_COUNTER_UD -- requirements
Module: gray_counter_ud

Interface
REQ-001 SHALL have parameter N, default 4, meaning counter width in bits (legal range 2..32).
REQ-002 SHALL have parameter RESET_GRAY, default 0, meaning the Gray-coded value of q after reset (N bits).
REQ-003 SHALL have parameter SATURATE, default 0, meaning 0 = wrap at terminal value and 1 = hold at terminal value.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rstn, input, 1, reset, asynchronous and active-low.
REQ-006 SHALL have port clear, input, 1, synchronous clear of the count to Gray 0.
REQ-007 SHALL have port load, input, 1, synchronous load of load_value.
REQ-008 SHALL have port load_value, input, N, the value to load, Gray-coded.
REQ-009 SHALL have port enable, input, 1, step the count by one on this edge.
REQ-010 SHALL have port up, input, 1, step direction: 1 = increment and 0 = decrement, in binary order.
REQ-011 SHALL have port q, output, N, registered Gray-coded count.
REQ-012 SHALL have port bin, output, N, registered binary equivalent of q.
REQ-013 SHALL have port wrap, output, 1, registered one-cycle pulse marking a wrap-around.
REQ-014 SHALL have port at_max, output, 1, registered flag: bin equals all-ones.
REQ-015 SHALL have port at_min, output, 1, registered flag: bin equals zero.

Function
REQ-016 SHALL hold the count internally in binary and derive q as bin ^ (bin >> 1) from the same next-state value, so that q and bin always update on the same edge.
REQ-017 SHALL convert load_value Gray-to-binary with an iterative XOR prefix from the MSB, implemented combinationally.
REQ-018 SHALL apply per-edge priority: clear, then load, then enable, then hold.
REQ-019 SHALL, on clear: q=0, bin=0, wrap=0.
REQ-020 SHALL, on load: q=load_value, bin=Gray-to-binary(load_value), wrap=0, with enable and up ignored that edge.
REQ-021 SHALL, on enable with up=1: bin_next = bin+1 modulo 2^N.
REQ-022 SHALL, on enable with up=0: bin_next = bin-1 modulo 2^N.
REQ-023 SHALL, when SATURATE=0, let an enabled step from all-ones (up=1) or from zero (up=0) wrap, and set wrap=1 for exactly the following cycle.
REQ-024 SHALL, when SATURATE=1, make an enabled step beyond the terminal value a no-op (q and bin unchanged), with wrap held at 0 permanently.
REQ-025 SHALL make q change in at most one bit between consecutive cycles for any enabled step, including a wrap step.
REQ-026 SHALL deassert wrap on every edge that does not itself cause a wrap, including when enable=0.
REQ-027 SHALL compute at_max and at_min from bin_next and register them, so they are coincident with bin.
REQ-028 SHALL allow up to change on any cycle; the direction takes effect on the same edge, with no turnaround cycle.
REQ-029 SHALL have no combinational path from any input to any output.

Reset
REQ-030 SHALL, while rstn=0 and independent of clk: q=RESET_GRAY, bin=Gray-to-binary(RESET_GRAY), wrap=0, with at_max and at_min consistent with that bin.
REQ-031 SHALL, on rstn deassertion, perform its first update on the first rising clk edge with rstn=1; rstn asserted mid-count SHALL immediately force the reset values of REQ-030.

Verification (N=4 unless stated)
REQ-032 SHALL cover: reset with RESET_GRAY=0, then enable=1, up=1 for 16 cycles -> q follows 0000,0001,0011,...,1000,0000; wrap=1 only in the cycle after the 1000->0000 edge; single-bit q change on every edge.
REQ-033 SHALL cover: load=1, load_value=0111 -> next cycle q=0111, bin=5; then enable=1, up=1 for 3 cycles -> bin=8, q=1100.
REQ-034 SHALL cover: from bin=0 with up=0, enable=1 and SATURATE=0 -> bin=15, q=1000, wrap pulse, at_max=1; the same stimulus with SATURATE=1 -> bin stays 0, at_min=1, wrap=0.
REQ-035 SHALL cover: clear, load and enable all asserted on one edge -> q=0; load and enable asserted together -> loaded value, no step.
REQ-036 SHALL cover: rstn pulsed low mid-cycle while counting (RESET_GRAY=0110) -> q=0110 and bin=4 immediately, without waiting for a clock edge; counting resumes from 4 on the first edge after rstn=1.
REQ-037 SHALL cover: random enable, up, load and clear for 10k cycles with N=7 -> a scoreboard matches bin and q every cycle, and q=bin^(bin>>1) always holds.

Source files
------------

// File: rtl/gray_counter_ud.sv
// ----------------------------------------------------------------------------
// gray_counter_ud
//
// Up/down counter that keeps its state in binary and presents both the binary
// count and its Gray-coded equivalent. Each enabled step changes q by exactly
// one bit, including the step across the terminal value. Optional saturation
// turns the terminal step into a no-op instead of a wrap.
//
// Parameters
//   N           counter width in bits (2..32)
//   RESET_GRAY  Gray-coded value of q while rstn is low
//   SATURATE    0 = wrap at the terminal value, 1 = hold at the terminal value
//
// Ports
//   clk         clock; all state changes on its rising edge
//   rstn        asynchronous active-low reset
//   clear       synchronous clear to zero (highest priority)
//   load        synchronous load of load_value (Gray-coded)
//   load_value  value to load, Gray-coded
//   enable      step the count by one on this edge
//   up          step direction: 1 = increment, 0 = decrement (binary order)
//   q           registered Gray-coded count
//   bin         registered binary count, always equal to gray-to-binary(q)
//   wrap        registered one-cycle pulse after a wrap-around step
//   at_max      registered flag, bin is all ones
//   at_min      registered flag, bin is zero
// ----------------------------------------------------------------------------
module gray_counter_ud #(
    parameter int           N          = 4,
    parameter logic [N-1:0] RESET_GRAY = '0,
    parameter int           SATURATE   = 0
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         clear,
    input  logic         load,
    input  logic [N-1:0] load_value,
    input  logic         enable,
    input  logic         up,
    output logic [N-1:0] q,
    output logic [N-1:0] bin,
    output logic         wrap,
    output logic         at_max,
    output logic         at_min
);

    // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above
    // it, built as a running prefix from the MSB down.
    function automatic logic [N-1:0] gray2bin(input logic [N-1:0] g);
        logic [N-1:0] b;
        b[N-1] = g[N-1];
        for (int i = N - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    localparam logic [N-1:0] RESET_BIN  = gray2bin(RESET_GRAY);
    localparam logic [N-1:0] ALL_ONES   = '1;
    localparam logic [N-1:0] ONE        = {{(N-1){1'b0}}, 1'b1};
    localparam bit           SAT_EN     = (SATURATE != 0);
    localparam bit           RESET_MAX  = (RESET_BIN == ALL_ONES);
    localparam bit           RESET_MIN  = (RESET_BIN == '0);

    logic [N-1:0] bin_q, bin_d;
    logic [N-1:0] q_q, q_d;
    logic         wrap_q, wrap_d;
    logic         at_max_q, at_max_d;
    logic         at_min_q, at_min_d;
    logic [N-1:0] load_bin;
    logic         at_top;
    logic         at_bot;

    // ------------------------------------------------------------------------
    // Next-state logic. Priority: clear, load, enable, hold.
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        bin_d    = bin_q;
        wrap_d   = 1'b0;
        load_bin = gray2bin(load_value);
        at_top   = (bin_q == ALL_ONES);
        at_bot   = (bin_q == '0);

        if (clear) begin
            bin_d = '0;
        end else if (load) begin
            bin_d = load_bin;
        end else if (enable) begin
            if (up) begin
                if (!at_top) begin
                    bin_d = bin_q + ONE;
                end else if (!SAT_EN) begin
                    bin_d  = '0;
                    wrap_d = 1'b1;
                end
            end else begin
                if (!at_bot) begin
                    bin_d = bin_q - ONE;
                end else if (!SAT_EN) begin
                    bin_d  = ALL_ONES;
                    wrap_d = 1'b1;
                end
            end
        end
    end

    // q and the flags are derived from the same next-state binary value, so
    // every output register updates on the same edge as bin.
    always_comb begin
        q_d      = bin_d ^ (bin_d >> 1);
        at_max_d = (bin_d == ALL_ONES);
        at_min_d = (bin_d == '0);
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (!rstn) begin
            bin_q    <= RESET_BIN;
            q_q      <= RESET_GRAY;
            wrap_q   <= 1'b0;
            at_max_q <= RESET_MAX;
            at_min_q <= RESET_MIN;
        end else begin
            bin_q    <= bin_d;
            q_q      <= q_d;
            wrap_q   <= wrap_d;
            at_max_q <= at_max_d;
            at_min_q <= at_min_d;
        end
    end

    assign q      = q_q;
    assign bin    = bin_q;
    assign wrap   = wrap_q;
    assign at_max = at_max_q;
    assign at_min = at_min_q;

endmodule

// File: tb/tb_gray_counter_ud.sv
// ----------------------------------------------------------------------------
// tb_gray_counter_ud
//
// Self-checking bench for gray_counter_ud. Four instances share one clock:
//   dut_a  N=4, RESET_GRAY=0,    SATURATE=0
//   dut_b  N=4, RESET_GRAY=0,    SATURATE=1   (same stimulus as dut_a)
//   dut_c  N=4, RESET_GRAY=0110, SATURATE=0   (mid-count async reset)
//   dut_d  N=7, RESET_GRAY=0,    SATURATE=0   (random stimulus, scoreboard)
// Inputs change 1 time unit after a rising edge; outputs are sampled there.
// ----------------------------------------------------------------------------
module tb_gray_counter_ud;

    logic clk;
    int   n_checks = 0;
    int   n_fails  = 0;

    // dut_a / dut_b shared stimulus
    logic       rstn;
    logic       clear, load, enable, up;
    logic [3:0] load_value;
    logic [3:0] a_q, a_bin, b_q, b_bin;
    logic       a_wrap, a_max, a_min, b_wrap, b_max, b_min;

    // dut_c stimulus
    logic       c_rstn, c_enable, c_up, c_clear, c_load;
    logic [3:0] c_load_value;
    logic [3:0] c_q, c_bin;
    logic       c_wrap, c_max, c_min;

    // dut_d stimulus
    logic       d_clear, d_load, d_enable, d_up;
    logic [6:0] d_load_value;
    logic [6:0] d_q, d_bin;
    logic       d_wrap, d_max, d_min;

    gray_counter_ud #(.N(4), .RESET_GRAY(4'b0000), .SATURATE(0)) dut_a (
        .clk(clk), .rstn(rstn), .clear(clear), .load(load), .load_value(load_value),
        .enable(enable), .up(up), .q(a_q), .bin(a_bin), .wrap(a_wrap),
        .at_max(a_max), .at_min(a_min)
    );

    gray_counter_ud #(.N(4), .RESET_GRAY(4'b0000), .SATURATE(1)) dut_b (
        .clk(clk), .rstn(rstn), .clear(clear), .load(load), .load_value(load_value),
        .enable(enable), .up(up), .q(b_q), .bin(b_bin), .wrap(b_wrap),
        .at_max(b_max), .at_min(b_min)
    );

    gray_counter_ud #(.N(4), .RESET_GRAY(4'b0110), .SATURATE(0)) dut_c (
        .clk(clk), .rstn(c_rstn), .clear(c_clear), .load(c_load), .load_value(c_load_value),
        .enable(c_enable), .up(c_up), .q(c_q), .bin(c_bin), .wrap(c_wrap),
        .at_max(c_max), .at_min(c_min)
    );

    gray_counter_ud #(.N(7), .RESET_GRAY(7'b0), .SATURATE(0)) dut_d (
        .clk(clk), .rstn(rstn), .clear(d_clear), .load(d_load), .load_value(d_load_value),
        .enable(d_enable), .up(d_up), .q(d_q), .bin(d_bin), .wrap(d_wrap),
        .at_max(d_max), .at_min(d_min)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference Gray-to-binary by exhaustive search: the binary b whose Gray
    // code b ^ (b >> 1) equals g.
    function automatic logic [6:0] ref_g2b(input logic [6:0] g);
        logic [6:0] r;
        r = '0;
        for (int b = 0; b < 128; b++) begin
            logic [6:0] bb;
            bb = 7'(b);
            if ((bb ^ (bb >> 1)) == g) r = bb;
        end
        return r;
    endfunction

    // Hand-written Gray sequence after steps 1..16 counting up from 0.
    logic [3:0] gseq [16] = '{
        4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100,
        4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000
    };

    initial begin
        logic [3:0] prev_q;
        logic [6:0] m_bin;
        logic       m_wrap;

        rstn = 1'b0; clear = 1'b0; load = 1'b0; enable = 1'b0; up = 1'b0; load_value = '0;
        c_rstn = 1'b0; c_clear = 1'b0; c_load = 1'b0; c_enable = 1'b0; c_up = 1'b0; c_load_value = '0;
        d_clear = 1'b0; d_load = 1'b0; d_enable = 1'b0; d_up = 1'b0; d_load_value = '0;

        // ---------------- reset state ----------------
        #12;
        check("rst_a_q",    a_q,    4'b0000);
        check("rst_a_bin",  a_bin,  4'd0);
        check("rst_a_wrap", a_wrap, 1'b0);
        check("rst_a_min",  a_min,  1'b1);
        check("rst_a_max",  a_max,  1'b0);
        check("rst_c_q",    c_q,    4'b0110);
        check("rst_c_bin",  c_bin,  4'd4);
        check("rst_c_min",  c_min,  1'b0);
        check("rst_c_max",  c_max,  1'b0);

        // ---------------- count up 16 steps ----------------
        rstn = 1'b1; enable = 1'b1; up = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            prev_q = a_q;
            step();
            check($sformatf("up%0d_a_q", k), a_q, gseq[k-1]);
            check($sformatf("up%0d_a_bin", k), a_bin, 32'(k % 16));
            check($sformatf("up%0d_onebit", k), $countones(prev_q ^ a_q), 1);
            check($sformatf("up%0d_a_wrap", k), a_wrap, (k == 16) ? 1'b1 : 1'b0);
            check($sformatf("up%0d_b_q", k), b_q, (k == 16) ? 4'b1000 : gseq[k-1]);
            check($sformatf("up%0d_b_wrap", k), b_wrap, 1'b0);
        end
        check("up16_a_min", a_min, 1'b1);
        check("up16_b_max", b_max, 1'b1);
        check("up16_b_bin", b_bin, 4'd15);

        // wrap deasserts on an idle edge
        enable = 1'b0;
        step();
        check("idle_a_wrap", a_wrap, 1'b0);
        check("idle_a_q",    a_q,    4'b0000);

        // ---------------- clear, then decrement from zero ----------------
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("clr_b_bin", b_bin, 4'd0);
        check("clr_b_min", b_min, 1'b1);

        enable = 1'b1; up = 1'b0;
        step();
        check("dn0_a_bin",  a_bin,  4'd15);
        check("dn0_a_q",    a_q,    4'b1000);
        check("dn0_a_wrap", a_wrap, 1'b1);
        check("dn0_a_max",  a_max,  1'b1);
        check("dn0_b_bin",  b_bin,  4'd0);
        check("dn0_b_min",  b_min,  1'b1);
        check("dn0_b_wrap", b_wrap, 1'b0);

        // ---------------- load with enable: load wins ----------------
        load = 1'b1; load_value = 4'b0111; enable = 1'b1; up = 1'b0;
        step();
        load = 1'b0;
        check("ld_a_q",    a_q,    4'b0111);
        check("ld_a_bin",  a_bin,  4'd5);
        check("ld_a_wrap", a_wrap, 1'b0);
        check("ld_b_bin",  b_bin,  4'd5);

        up = 1'b1;
        step(); check("ldup1_bin", a_bin, 4'd6);
        step(); check("ldup2_bin", a_bin, 4'd7);
        step(); check("ldup3_bin", a_bin, 4'd8);
        check("ldup3_q", a_q, 4'b1100);

        // ---------------- direction reversal, no turnaround ----------------
        up = 1'b0;
        step();
        check("rev_dn_bin", a_bin, 4'd7);
        check("rev_dn_q",   a_q,   4'b0100);
        up = 1'b1;
        step();
        check("rev_up_bin", a_bin, 4'd8);

        // ---------------- clear + load + enable: clear wins ----------------
        clear = 1'b1; load = 1'b1; load_value = 4'b0101; enable = 1'b1;
        step();
        clear = 1'b0; load = 1'b0;
        check("cle_a_q",   a_q,   4'b0000);
        check("cle_a_bin", a_bin, 4'd0);

        // ---------------- load terminal then step up ----------------
        load = 1'b1; load_value = 4'b1000; enable = 1'b0;
        step();
        load = 1'b0;
        check("ldmax_a_max", a_max, 1'b1);
        check("ldmax_b_bin", b_bin, 4'd15);
        enable = 1'b1; up = 1'b1;
        step();
        enable = 1'b0;
        check("wrapup_a_bin",  a_bin,  4'd0);
        check("wrapup_a_wrap", a_wrap, 1'b1);
        check("satup_b_bin",   b_bin,  4'd15);
        check("satup_b_q",     b_q,    4'b1000);
        check("satup_b_wrap",  b_wrap, 1'b0);

        // ---------------- dut_c: asynchronous reset mid-count ----------------
        check("c_hold_bin", c_bin, 4'd4);
        c_rstn = 1'b1; c_enable = 1'b1; c_up = 1'b1;
        step(); check("c_cnt1_bin", c_bin, 4'd5);
        step(); check("c_cnt2_bin", c_bin, 4'd6);
        step(); check("c_cnt3_bin", c_bin, 4'd7);
        #2;
        c_rstn = 1'b0;
        #1;
        check("c_arst_q",   c_q,   4'b0110);
        check("c_arst_bin", c_bin, 4'd4);
        step();
        check("c_inrst_bin", c_bin, 4'd4);
        #3;
        c_rstn = 1'b1;
        step();
        check("c_resume_bin", c_bin, 4'd5);
        check("c_resume_q",   c_q,   4'b0111);
        c_enable = 1'b0;

        // ---------------- dut_d: random run against a scoreboard ----------------
        m_bin = d_bin;
        check("d_start_bin", d_bin, 7'd0);
        for (int i = 0; i < 10000; i++) begin
            d_clear      = ($urandom_range(31) == 0);
            d_load       = ($urandom_range(15) == 0);
            d_load_value = 7'($urandom_range(127));
            d_enable     = ($urandom_range(3) != 0);
            d_up         = 1'($urandom_range(1));
            m_wrap = 1'b0;
            if (d_clear) begin
                m_bin = '0;
            end else if (d_load) begin
                m_bin = ref_g2b(d_load_value);
            end else if (d_enable) begin
                if (d_up) begin
                    if (m_bin == 7'd127) m_wrap = 1'b1;
                    m_bin = m_bin + 7'd1;
                end else begin
                    if (m_bin == 7'd0) m_wrap = 1'b1;
                    m_bin = m_bin - 7'd1;
                end
            end
            step();
            check("rnd_bin",  d_bin,  m_bin);
            check("rnd_q",    d_q,    m_bin ^ (m_bin >> 1));
            check("rnd_gray", d_q,    d_bin ^ (d_bin >> 1));
            check("rnd_wrap", d_wrap, m_wrap);
            check("rnd_max",  d_max,  (m_bin == 7'd127) ? 1'b1 : 1'b0);
            check("rnd_min",  d_min,  (m_bin == 7'd0) ? 1'b1 : 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
